key_cursor_ctrl: RTL and testbench

KEY_CURSOR_CTRL -- requirements
Module: key_cursor_ctrl

---
 rtl/key_cursor_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_key_cursor_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// key_cursor_ctrl
//
// Keyboard-driven cursor and two-cell selection controller for a board game.
// Level key states from a PS/2 decoder are edge-detected. Direction keys move
// a cursor with typematic auto-repeat. Enter/Esc select a first cell and then
// request a (selected cell, cursor cell) pair from the game logic through a
// valid/ready handshake.
//
// Parameters
//   BOARD_W, BOARD_H  board columns / rows (2..16)
//   REPEAT_DELAY      clk cycles from the first step to the first repeat step
//   REPEAT_PERIOD     clk cycles between later repeat steps
//   WRAP              1: cursor wraps at board edges, 0: cursor saturates
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   op[5:0]           key levels: 0 Enter, 1 Esc, 2 left, 3 right, 4 up, 5 down
//   busy              game logic busy; key presses are discarded while high
//   cur_x, cur_y      cursor cell
//   sel_active        a first cell is selected
//   sel_x, sel_y      selected cell
//   pair_valid        pair request offered to the game logic
//   pair_ready        game logic accepts the pair
// -----------------------------------------------------------------------------
module key_cursor_ctrl #(
  parameter int BOARD_W       = 8,
  parameter int BOARD_H       = 8,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int WRAP          = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       busy,
  output logic [3:0] cur_x,
  output logic [3:0] cur_y,
  output logic       sel_active,
  output logic [3:0] sel_x,
  output logic [3:0] sel_y,
  output logic       pair_valid,
  input  logic       pair_ready
);

  localparam int K_ENTER = 0;
  localparam int K_ESC   = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_UP    = 4;
  localparam int K_DOWN  = 5;

  // The repeat counter runs 0..limit-1 for either phase, so it only has to
  // hold the larger of the two intervals.
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [3:0]       X_LAST      = 4'(BOARD_W - 1);
  localparam logic [3:0]       Y_LAST      = 4'(BOARD_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_REQUEST  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_LEFT  = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_UP    = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

  state_t           state, state_nxt;
  dir_t             dir, dir_nxt;
  dir_t             new_dir;
  dir_t             step_dir;
  logic [5:0]       op_q;
  logic [5:0]       press;
  logic [5:0]       press_en;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;
  logic [CNT_W-1:0] rep_last;
  logic             rep_phase, rep_phase_nxt;
  logic             dir_held;
  logic             to_request;
  logic [3:0]       cur_x_nxt, cur_y_nxt;
  logic [3:0]       sel_x_nxt, sel_y_nxt;

  // One-cell move along an axis; dec selects the decrementing direction.
  function automatic logic [3:0] step_coord(input logic [3:0] pos,
                                            input logic       dec,
                                            input logic [3:0] last);
    logic [3:0] r;
    r = pos;
    if (dec) begin
      if (pos == 4'd0) r = (WRAP != 0) ? last : pos;
      else             r = pos - 4'd1;
    end else begin
      if (pos == last) r = (WRAP != 0) ? 4'd0 : pos;
      else             r = pos + 4'd1;
    end
    return r;
  endfunction

  // Press detection and direction arbitration (left > right > up > down).
  always_comb begin
    press    = op & ~op_q;
    press_en = busy ? 6'd0 : press;
    new_dir  = DIR_NONE;
    if      (press_en[K_LEFT])  new_dir = DIR_LEFT;
    else if (press_en[K_RIGHT]) new_dir = DIR_RIGHT;
    else if (press_en[K_UP])    new_dir = DIR_UP;
    else if (press_en[K_DOWN])  new_dir = DIR_DOWN;
  end

  // Selection state machine. Enter/Esc decisions use the cursor as it was
  // before any move in the same cycle; Esc outranks Enter.
  always_comb begin
    state_nxt  = state;
    sel_x_nxt  = sel_x;
    sel_y_nxt  = sel_y;
    to_request = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press_en[K_ENTER] && !press_en[K_ESC]) begin
          sel_x_nxt = cur_x;
          sel_y_nxt = cur_y;
          state_nxt = ST_SELECTED;
        end
      end
      ST_SELECTED: begin
        if (press_en[K_ESC]) begin
          state_nxt = ST_IDLE;
        end else if (press_en[K_ENTER]) begin
          if (cur_x == sel_x && cur_y == sel_y) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt  = ST_REQUEST;
            to_request = 1'b1;
          end
        end
      end
      ST_REQUEST: begin
        // pair_valid is high throughout this state, so ready alone completes it.
        if (pair_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Active direction and auto-repeat. Only the active direction's own key
  // level keeps the repeat alive; the request phase freezes the cursor.
  always_comb begin
    dir_nxt       = dir;
    rep_cnt_nxt   = rep_cnt;
    rep_phase_nxt = rep_phase;
    step_dir      = DIR_NONE;
    rep_last      = rep_phase ? PERIOD_LAST : DELAY_LAST;
    dir_held      = 1'b0;
    case (dir)
      DIR_LEFT:  dir_held = op[K_LEFT];
      DIR_RIGHT: dir_held = op[K_RIGHT];
      DIR_UP:    dir_held = op[K_UP];
      DIR_DOWN:  dir_held = op[K_DOWN];
      default:   dir_held = 1'b0;
    endcase

    if (busy || state == ST_REQUEST || to_request) begin
      dir_nxt       = DIR_NONE;
      rep_cnt_nxt   = '0;
      rep_phase_nxt = 1'b0;
    end else if (new_dir != DIR_NONE) begin
      step_dir      = new_dir;
      dir_nxt       = new_dir;
      rep_cnt_nxt   = '0;
      rep_phase_nxt = 1'b0;
    end else if (dir != DIR_NONE) begin
      if (!dir_held) begin
        dir_nxt       = DIR_NONE;
        rep_cnt_nxt   = '0;
        rep_phase_nxt = 1'b0;
      end else if (rep_cnt == rep_last) begin
        step_dir      = dir;
        rep_cnt_nxt   = '0;
        rep_phase_nxt = 1'b1;
      end else begin
        rep_cnt_nxt = rep_cnt + 1'b1;
      end
    end
  end

  // Cursor update.
  always_comb begin
    cur_x_nxt = cur_x;
    cur_y_nxt = cur_y;
    case (step_dir)
      DIR_LEFT:  cur_x_nxt = step_coord(cur_x, 1'b1, X_LAST);
      DIR_RIGHT: cur_x_nxt = step_coord(cur_x, 1'b0, X_LAST);
      DIR_UP:    cur_y_nxt = step_coord(cur_y, 1'b1, Y_LAST);
      DIR_DOWN:  cur_y_nxt = step_coord(cur_y, 1'b0, Y_LAST);
      default: begin
        cur_x_nxt = cur_x;
        cur_y_nxt = cur_y;
      end
    endcase
  end

  // Register stage: op_q samples every cycle, even while busy, so a key held
  // through busy does not register as a press afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      dir        <= DIR_NONE;
      op_q       <= 6'd0;
      rep_cnt    <= '0;
      rep_phase  <= 1'b0;
      cur_x      <= 4'd0;
      cur_y      <= 4'd0;
      sel_x      <= 4'd0;
      sel_y      <= 4'd0;
      sel_active <= 1'b0;
      pair_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      op_q       <= op;
      rep_cnt    <= rep_cnt_nxt;
      rep_phase  <= rep_phase_nxt;
      cur_x      <= cur_x_nxt;
      cur_y      <= cur_y_nxt;
      sel_x      <= sel_x_nxt;
      sel_y      <= sel_y_nxt;
      sel_active <= (state_nxt != ST_IDLE);
      pair_valid <= (state_nxt == ST_REQUEST);
    end
  end

endmodule

// File: tb/tb_key_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_cursor_ctrl
//
// Bench for key_cursor_ctrl. Two instances (saturating and wrapping) share the
// same stimulus and are tracked by a behavioural cursor/selection model.
// Directed scenarios are followed by a randomized key-level run.
// -----------------------------------------------------------------------------
module tb_key_cursor_ctrl;

  localparam int W   = 8;
  localparam int H   = 8;
  localparam int DLY = 10;
  localparam int PER = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = 6'd0;
  logic       busy = 1'b0;
  logic       pair_ready = 1'b0;

  logic [3:0] cx0, cy0, sx0, sy0;
  logic       sa0, pv0;
  logic [3:0] cx1, cy1, sx1, sy1;
  logic       sa1, pv1;

  always #5 clk = ~clk;

  key_cursor_ctrl #(
    .BOARD_W(W), .BOARD_H(H), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .WRAP(0)
  ) dut0 (
    .clk(clk), .rst(rst), .op(op), .busy(busy),
    .cur_x(cx0), .cur_y(cy0), .sel_active(sa0), .sel_x(sx0), .sel_y(sy0),
    .pair_valid(pv0), .pair_ready(pair_ready)
  );

  key_cursor_ctrl #(
    .BOARD_W(W), .BOARD_H(H), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .WRAP(1)
  ) dut1 (
    .clk(clk), .rst(rst), .op(op), .busy(busy),
    .cur_x(cx1), .cur_y(cy1), .sel_active(sa1), .sel_x(sx1), .sel_y(sy1),
    .pair_valid(pv1), .pair_ready(pair_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // Behavioural model, index 0 = saturating, 1 = wrapping.
  // mode: 0 nothing selected, 1 first cell selected, 2 pair offered.
  // dir: -1 none, 0 left, 1 right, 2 up, 3 down. wait: edges until next repeat.
  int         m_cx[2], m_cy[2], m_sx[2], m_sy[2], m_mode[2], m_dir[2], m_wait[2];
  logic [5:0] m_prev;

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_cx[w] = 0; m_cy[w] = 0; m_sx[w] = 0; m_sy[w] = 0;
      m_mode[w] = 0; m_dir[w] = -1; m_wait[w] = 0;
    end
    m_prev = 6'd0;
  endtask

  function automatic int move1(input int pos, input int delta, input int size, input int wrap);
    int p;
    p = pos + delta;
    if (p < 0)     p = wrap ? size - 1 : 0;
    if (p >= size) p = wrap ? 0 : size - 1;
    return p;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [5:0] pr;
    bit en, es, freeze;
    int nd, mv;
    pr = op & ~m_prev;
    for (int w = 0; w < 2; w++) begin
      en = pr[0] && !busy;
      es = pr[1] && !busy;
      freeze = 0;
      mv = -1;
      nd = -1;
      if (!busy)
        for (int k = 3; k >= 0; k--)
          if (pr[2 + k]) nd = k;

      if (m_mode[w] == 2) begin
        freeze = 1;
        if (pair_ready) m_mode[w] = 0;
      end else if (m_mode[w] == 0) begin
        if (en && !es) begin
          m_sx[w] = m_cx[w]; m_sy[w] = m_cy[w]; m_mode[w] = 1;
        end
      end else begin
        if (es) m_mode[w] = 0;
        else if (en) begin
          if (m_cx[w] == m_sx[w] && m_cy[w] == m_sy[w]) m_mode[w] = 0;
          else begin
            m_mode[w] = 2; freeze = 1;
          end
        end
      end

      if (busy || freeze) m_dir[w] = -1;
      else if (nd >= 0) begin
        mv = nd; m_dir[w] = nd; m_wait[w] = DLY;
      end else if (m_dir[w] >= 0) begin
        if (!op[2 + m_dir[w]]) m_dir[w] = -1;
        else begin
          m_wait[w]--;
          if (m_wait[w] == 0) begin
            mv = m_dir[w]; m_wait[w] = PER;
          end
        end
      end

      case (mv)
        0: m_cx[w] = move1(m_cx[w], -1, W, w);
        1: m_cx[w] = move1(m_cx[w],  1, W, w);
        2: m_cy[w] = move1(m_cy[w], -1, H, w);
        3: m_cy[w] = move1(m_cy[w],  1, H, w);
        default: ;
      endcase
    end
    m_prev = op;
  endtask

  task automatic cmp_inst(input int w, input int cx, input int cy, input int sa,
                          input int sx, input int sy, input int pv);
    check($sformatf("w%0d cur_x", w), cx, m_cx[w]);
    check($sformatf("w%0d cur_y", w), cy, m_cy[w]);
    check($sformatf("w%0d sel_active", w), sa, (m_mode[w] != 0) ? 1 : 0);
    check($sformatf("w%0d sel_x", w), sx, m_sx[w]);
    check($sformatf("w%0d sel_y", w), sy, m_sy[w]);
    check($sformatf("w%0d pair_valid", w), pv, (m_mode[w] == 2) ? 1 : 0);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    cmp_inst(0, cx0, cy0, sa0, sx0, sy0, pv0);
    cmp_inst(1, cx1, cy1, sa1, sx1, sy1, pv1);
  endtask

  task automatic press_key(input logic [5:0] m);
    op = m;
    tick();
    op = 6'd0;
    tick();
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst pair_valid0", pv0, 0);
    check("rst sel_active0", sa0, 0);
    check("rst cur_x0", cx0, 0);
    check("rst cur_y0", cy0, 0);
    check("rst sel_x0", sx0, 0);
    check("rst sel_y0", sy0, 0);
    check("rst pair_valid1", pv1, 0);
    check("rst cur_x1", cx1, 0);
    check("rst cur_y1", cy1, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [5:0] K_ENT = 6'b000001;
  localparam logic [5:0] K_ESC = 6'b000010;
  localparam logic [5:0] K_LFT = 6'b000100;
  localparam logic [5:0] K_RGT = 6'b001000;
  localparam logic [5:0] K_UP  = 6'b010000;
  localparam logic [5:0] K_DWN = 6'b100000;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    tick();

    // Auto-repeat timing: right held 20 cycles from (0,0).
    op = K_RGT;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1)  check("rep first step", cx0, 1);
      if (n == 10) check("rep before delay", cx0, 1);
      if (n == 11) check("rep after delay", cx0, 2);
      if (n == 14) check("rep before period", cx0, 2);
      if (n == 15) check("rep period 1", cx0, 3);
      if (n == 19) check("rep period 2", cx0, 4);
    end
    op = 6'd0;
    repeat (6) tick();
    check("rep stop on release", cx0, 4);

    // Left edge at (0,3): saturate vs wrap.
    do_reset();
    repeat (3) press_key(K_DWN);
    press_key(K_LFT);
    check("edge sat x", cx0, 0);
    check("edge sat y", cy0, 3);
    check("edge wrap x", cx1, 7);
    check("edge wrap y", cy1, 3);

    // Pair request with stalled handshake.
    do_reset();
    repeat (2) press_key(K_RGT);
    repeat (2) press_key(K_DWN);
    press_key(K_ENT);
    check("sel set", sa0, 1);
    check("sel x", sx0, 2);
    check("sel y", sy0, 2);
    press_key(K_RGT);
    op = K_ENT;
    tick();
    check("req valid", pv0, 1);
    op = K_ENT | K_RGT;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("req hold valid", pv0, 1);
      check("req hold cur_x", cx0, 3);
      check("req hold sel_x", sx0, 2);
    end
    pair_ready = 1'b1;
    tick();
    pair_ready = 1'b0;
    check("req done valid", pv0, 0);
    check("req done sel", sa0, 0);
    op = 6'd0;
    tick();
    check("req done cur_x", cx0, 3);

    // Deselect by Enter on same cell, and by Enter+Esc together.
    do_reset();
    repeat (5) press_key(K_RGT);
    repeat (5) press_key(K_DWN);
    press_key(K_ENT);
    check("same sel set", sa0, 1);
    press_key(K_ENT);
    check("same deselect", sa0, 0);
    check("same no req", pv0, 0);
    repeat (4) press_key(K_LFT);
    repeat (4) press_key(K_UP);
    press_key(K_ENT);
    check("esc sel set", sa0, 1);
    check("esc sel x", sx0, 1);
    op = K_ENT | K_ESC;
    tick();
    check("esc deselect", sa0, 0);
    check("esc no req", pv0, 0);
    op = 6'd0;
    tick();

    // Simultaneous directions, busy, reset during request.
    do_reset();
    repeat (4) press_key(K_RGT);
    repeat (4) press_key(K_DWN);
    op = K_LFT | K_UP;
    tick();
    check("prio x", cx0, 3);
    check("prio y", cy0, 4);
    op = 6'd0;
    tick();
    busy = 1'b1;
    op = K_RGT;
    tick();
    check("busy no move", cx0, 3);
    op = 6'd0;
    tick();
    busy = 1'b0;
    tick();
    press_key(K_ENT);
    press_key(K_RGT);
    op = K_ENT;
    tick();
    check("pre-rst valid", pv0, 1);
    op = 6'd0;
    do_reset();
    tick();

    // Randomized key levels.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 15) == 0) op[b] = ~op[b];
      busy = ($urandom_range(0, 9) == 0);
      pair_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
